// File: rtl/wb_slave_mem_if.sv
// wb_slave_mem_if: Wishbone B3 bus between the MAC DMA master and the slave memory.
interface wb_slave_mem_if;
    logic [31:0] wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic        wb_ack_o;
    logic        wb_err_o;
    modport master(
        output wb_adr_i, wb_sel_i, wb_we_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );
    modport slave(
        input  wb_adr_i, wb_sel_i, wb_we_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_slave_mem.sv
// wb_slave_mem: Wishbone B3 slave word memory with wait states, bursts and error termination.
// Defining WB_MEM_STATS_EN adds saturating read/write/error beat counters.
module wb_slave_mem #(
    parameter int          ADDR_W      = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
`ifdef WB_MEM_STATS_EN
    output logic [15:0] rd_cnt,
    output logic [15:0] wr_cnt,
    output logic [15:0] err_cnt,
`endif
    wb_slave_mem_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, BEAT, BURST} state_t;
    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic [31:0]       addr, addr_n, dat_q, wrap_mask, nxt;
    logic [ADDR_W-1:0] idx;
    logic              bad, beat, ack, err;
    logic [31:0]       mem [2**ADDR_W];
    assign idx = addr[ADDR_W+1:2];
    assign bad = (|addr[1:0]) | (addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]);
    assign beat = bus.wb_cyc_i & ((state == BEAT) | ((state == BURST) & bus.wb_stb_i));
    assign ack = beat & ~bad;
    assign err = beat & bad;
    // wrap modes only let the low word-index bits roll over
    assign wrap_mask = (bus.wb_bte_i == 2'b01) ? 32'h0000_000F :
                       (bus.wb_bte_i == 2'b10) ? 32'h0000_001F :
                       (bus.wb_bte_i == 2'b11) ? 32'h0000_003F : 32'hFFFF_FFFF;
    assign nxt = (addr & ~wrap_mask) | ((addr + 32'd4) & wrap_mask);
    always_ff @(posedge wb_clk or negedge wb_rst)
        if (!wb_rst) begin
            state <= IDLE;
            cnt   <= '0;
            addr  <= '0;
            dat_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            addr  <= addr_n;
            dat_q <= bus.wb_dat_o;
        end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        addr_n  = addr;
        if (state == IDLE) begin
            if (bus.wb_cyc_i & bus.wb_stb_i) begin
                addr_n  = bus.wb_adr_i;
                state_n = (WAIT_STATES == 0) ? BEAT : WAIT;
                cnt_n   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
            end
        end else if (!bus.wb_cyc_i) begin
            state_n = IDLE;
        end else if (state == WAIT) begin
            cnt_n   = (cnt == 4'd0) ? cnt : cnt - 4'd1;
            state_n = (cnt == 4'd0) ? BEAT : WAIT;
        end else if (beat) begin
            addr_n  = nxt;
            state_n = (err | (bus.wb_cti_i != 3'b010)) ? IDLE : BURST;
        end
    end
    always_comb begin
        bus.wb_ack_o = ack;
        bus.wb_err_o = err;
        bus.wb_dat_o = err ? 32'd0 : (ack & ~bus.wb_we_i) ? mem[idx] : dat_q;
    end
    always_ff @(posedge wb_clk)
        if (ack & bus.wb_we_i)
            for (int i = 0; i < 4; i++)
                if (bus.wb_sel_i[i]) mem[idx][8*i +: 8] <= bus.wb_dat_i[8*i +: 8];
`ifdef WB_MEM_STATS_EN
    always_ff @(posedge wb_clk or negedge wb_rst)
        if (!wb_rst) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            if (ack & ~bus.wb_we_i & ~&rd_cnt) rd_cnt <= rd_cnt + 16'd1;
            if (ack & bus.wb_we_i & ~&wr_cnt) wr_cnt <= wr_cnt + 16'd1;
            if (err & ~&err_cnt) err_cnt <= err_cnt + 16'd1;
        end
`endif
endmodule

// File: tb/tb_wb_slave_mem.sv
// tb_wb_slave_mem: randomized Wishbone master with a word-array reference model.
// Stats checks are compiled in only when WB_MEM_STATS_EN is defined.
module tb_wb_slave_mem;
    localparam int WS = 1;
    logic clk = 0, rst_n = 1, chk_en = 0;
    logic exp_ack = 0, exp_err = 0;
    logic [31:0] exp_dat = 0;
    logic [31:0] model [1024];
    logic [31:0] rdq [$];
    int acks, checks = 0, errors = 0;
    always #5 clk = ~clk;
    wb_slave_mem_if bus();
`ifdef WB_MEM_STATS_EN
    logic [15:0] rd_cnt, wr_cnt, err_cnt;
`endif
    wb_slave_mem #(.ADDR_W(10), .BASE_ADDR(32'h0), .WAIT_STATES(WS)) dut (
        .wb_clk(clk),
        .wb_rst(rst_n),
`ifdef WB_MEM_STATS_EN
        .rd_cnt(rd_cnt),
        .wr_cnt(wr_cnt),
        .err_cnt(err_cnt),
`endif
        .bus(bus)
    );
    always @(negedge clk)
        if (chk_en) begin
            checks++;
            if (bus.wb_ack_o !== exp_ack || bus.wb_err_o !== exp_err || bus.wb_dat_o !== exp_dat) begin
                errors++;
                $display("FAIL bus @%0t: ack=%b err=%b dat=%h, expected ack=%b err=%b dat=%h",
                         $time, bus.wb_ack_o, bus.wb_err_o, bus.wb_dat_o, exp_ack, exp_err, exp_dat);
            end
        end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    function automatic bit is_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'h1000);
    endfunction
    // address of beat k: linear adds 4 per beat, wraps stay inside an aligned 16/32/64-byte block
    function automatic logic [31:0] burst_addr(input logic [31:0] start, input logic [1:0] bte, input int k);
        logic [31:0] blk;
        if (bte == 2'b00) return start + 32'(4 * k);
        blk = 32'd8 << bte;
        return start - (start % blk) + ((start % blk) + 32'(4 * k)) % blk;
    endfunction
    task automatic respond(input bit we, input logic [31:0] a, input logic [3:0] sel,
                           input logic [31:0] d, output bit bad);
        bad = is_bad(a);
        exp_ack = !bad;
        exp_err = bad;
        if (bad) exp_dat = 0;
        else if (we) begin
            for (int i = 0; i < 4; i++)
                if (sel[i]) model[a[11:2]][8*i +: 8] = d[8*i +: 8];
        end else exp_dat = model[a[11:2]];
    endtask
    task automatic classic(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel,
                           input logic [2:0] cti, output logic [31:0] rd, output logic ak, output logic er);
        bit bad;
        bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = we; bus.wb_adr_i = a;
        bus.wb_dat_i = d; bus.wb_sel_i = sel; bus.wb_cti_i = cti; bus.wb_bte_i = 2'b00;
        tick;
        repeat (WS) tick;
        respond(we, a, sel, d, bad);
        @(negedge clk);
        rd = bus.wb_dat_o; ak = bus.wb_ack_o; er = bus.wb_err_o;
        tick;
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; exp_ack = 0; exp_err = 0;
        tick;
    endtask
    task automatic burst(input bit we, input logic [31:0] start, input logic [1:0] bte, input int n,
                         input logic [31:0] dbase, input int gap_at, input int gap_len);
        bit bad;
        logic [31:0] a, d;
        rdq.delete();
        acks = 0;
        bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = we; bus.wb_bte_i = bte; bus.wb_sel_i = 4'hF;
        for (int k = 0; k < n; k++) begin
            a = burst_addr(start, bte, k);
            d = (dbase == 0) ? $urandom : dbase + 32'(k);
            bus.wb_adr_i = a; bus.wb_dat_i = d;
            bus.wb_cti_i = (k == n - 1) ? 3'b111 : 3'b010;
            if (k == 0) begin
                tick;
                repeat (WS) tick;
            end else if (k == gap_at) begin
                bus.wb_stb_i = 0;
                repeat (gap_len) tick;
                bus.wb_stb_i = 1;
            end
            respond(we, a, 4'hF, d, bad);
            @(negedge clk);
            if (bus.wb_ack_o) acks++;
            rdq.push_back(bus.wb_dat_o);
            tick;
            exp_ack = 0; exp_err = 0;
            if (bad) break;
        end
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
        tick;
    endtask
    initial begin
        #3_000_000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end
    initial begin
        logic [31:0] rd, a;
        logic ak, er;
        bit bad;
        int r;
`ifdef WB_MEM_STATS_EN
        logic [15:0] e0;
`endif
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0; bus.wb_adr_i = 0;
        bus.wb_dat_i = 0; bus.wb_sel_i = 0; bus.wb_cti_i = 0; bus.wb_bte_i = 0;
        #2 rst_n = 0;
        chk_en = 1;
        #1;
        check("reset_ack", 32'(bus.wb_ack_o), 0);
        check("reset_err", 32'(bus.wb_err_o), 0);
        check("reset_dat", bus.wb_dat_o, 0);
        repeat (2) tick;
        rst_n = 1;
        tick;
        for (int b = 0; b < 4; b++) burst(1, 32'(b * 32'h400), 2'b00, 256, 0, -1, 0);
        classic(1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, rd, ak, er);
        check("classic_wr_ack", 32'(ak), 1);
        classic(0, 32'h10, 0, 4'hF, 3'b111, rd, ak, er);
        check("classic_rd_ack", 32'(ak), 1);
        check("classic_rd_dat", rd, 32'hDEADBEEF);
        classic(1, 32'h40, 32'hFFFFFFFF, 4'hF, 3'b000, rd, ak, er);
        classic(1, 32'h40, 32'h11223344, 4'b0101, 3'b000, rd, ak, er);
        classic(0, 32'h40, 0, 4'hF, 3'b000, rd, ak, er);
        check("byte_en_dat", rd, 32'hFF22FF44);
        burst(1, 32'h20, 2'b00, 4, 32'hA0000000, -1, 0);
        check("lin_wr_acks", 32'(acks), 4);
        burst(0, 32'h20, 2'b00, 4, 0, -1, 0);
        check("lin_rd_acks", 32'(acks), 4);
        check("lin_rd_0", rdq[0], 32'hA0000000);
        check("lin_rd_3", rdq[3], 32'hA0000003);
        for (int i = 0; i < 4; i++) classic(1, 32'h30 + 32'(4 * i), 32'hC0 + 32'(4 * i), 4'hF, 3'b000, rd, ak, er);
        burst(0, 32'h38, 2'b01, 4, 0, 2, 2);
        check("wrap4_acks", 32'(acks), 4);
        check("wrap4_b0", rdq[0], 32'hC8);
        check("wrap4_b1", rdq[1], 32'hCC);
        check("wrap4_b2", rdq[2], 32'hC0);
        check("wrap4_b3", rdq[3], 32'hC4);
`ifdef WB_MEM_STATS_EN
        e0 = err_cnt;
`endif
        classic(1, 32'h1002, 32'h0BAD0BAD, 4'hF, 3'b000, rd, ak, er);
        check("err_mis_err", 32'(er), 1);
        check("err_mis_ack", 32'(ak), 0);
        classic(1, 32'h1000, 32'h0BAD0BAD, 4'hF, 3'b000, rd, ak, er);
        check("err_oob_err", 32'(er), 1);
        classic(1, 32'h12, 32'h0BAD0BAD, 4'hF, 3'b000, rd, ak, er);
        check("err_low_dat", rd, 0);
        classic(0, 32'h10, 0, 4'hF, 3'b000, rd, ak, er);
        check("err_mem_kept", rd, 32'hDEADBEEF);
`ifdef WB_MEM_STATS_EN
        check("err_cnt", 32'(err_cnt), 32'(e0) + 3);
`endif
        burst(1, 32'hFF8, 2'b00, 4, 0, -1, 0);
        check("top_burst_acks", 32'(acks), 2);
        bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 0; bus.wb_adr_i = 32'h20;
        bus.wb_cti_i = 3'b010; bus.wb_bte_i = 2'b00;
        tick;
        repeat (WS) tick;
        respond(0, 32'h20, 4'hF, 0, bad);
        #1 rst_n = 0;
        exp_ack = 0; exp_err = 0; exp_dat = 0;
        #1;
        check("rst_mid_ack", 32'(bus.wb_ack_o), 0);
        check("rst_mid_dat", bus.wb_dat_o, 0);
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
        repeat (2) tick;
        rst_n = 1;
        tick;
        classic(0, 32'h28, 0, 4'hF, 3'b000, rd, ak, er);
        check("post_rst_dat", rd, 32'hA0000002);
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                a = 32'($urandom_range(0, 1023)) << 2;
                if (r == 0) a = 32'h1000 + (32'($urandom_range(0, 1023)) << 2);
                if (r == 1) a = a | 32'($urandom_range(1, 3));
                classic($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)),
                        (r == 4) ? 3'b111 : (r == 3) ? 3'b001 : 3'b000, rd, ak, er);
            end else begin
                a = (r == 9) ? 32'h1000 - (32'($urandom_range(1, 6)) << 2) : 32'($urandom_range(0, 1023)) << 2;
                burst($urandom_range(0, 1) == 1, a, (r == 9) ? 2'b00 : 2'($urandom_range(0, 3)),
                      $urandom_range(1, 16), 0, $urandom_range(1, 16), $urandom_range(1, 3));
            end
        end
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
